// File: rtl/cmp_serial.sv
// cmp_serial: bit-serial, MSB-first magnitude comparator that examines one bit pair per
// cycle and exits early on the first differing bit, optionally treating operands as signed.
module cmp_serial #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             aeb,
  output logic             agb,
  output logic             alb
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;

  logic             a_bit;
  logic             b_bit;
  logic             sign_pos;
  logic             a_greater;

  // A differing pair favours A when A holds the 1, except at a signed sign bit,
  // where a 1 marks A as the negative (smaller) operand.
  function automatic logic a_wins(input logic bit_a, input logic sign_bit);
    return bit_a ^ sign_bit;
  endfunction

  assign a_bit     = a_q[idx];
  assign b_bit     = b_q[idx];
  assign sign_pos  = (idx == IDX_TOP) && sgn_q;
  assign a_greater = a_wins(a_bit, sign_pos);

  // Operand capture on start acceptance; the compare in progress never sees later input changes.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= (SIGNED_EN != 0) ? is_signed : 1'b0;
    end
  end

  // Control FSM; result flags are only rewritten on termination so they hold while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= IDX_TOP;
      busy  <= 1'b0;
      done  <= 1'b0;
      aeb   <= 1'b0;
      agb   <= 1'b0;
      alb   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            idx   <= IDX_TOP;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (a_bit != b_bit) begin
            aeb   <= 1'b0;
            agb   <= a_greater;
            alb   <= !a_greater;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == '0) begin
            aeb   <= 1'b1;
            agb   <= 1'b0;
            alb   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - IDX_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_serial.sv
// Bench for cmp_serial: directed cases with literal expectations plus a randomized run,
// all checked every cycle against an arithmetic latency/result model.
module tb_cmp_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         start_u;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy, done, aeb, agb, alb;
  logic         busy_u, done_u, aeb_u, agb_u, alb_u;

  int   n_pass  = 0;
  int   n_total = 0;
  logic chk_en  = 1'b0;

  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [2:0] m_res  = 3'b000;
  logic [2:0] m_pend = 3'b000;
  int         m_left = 0;

  always #5 clk = ~clk;

  cmp_serial #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .is_signed(is_signed),
    .busy(busy), .done(done), .aeb(aeb), .agb(agb), .alb(alb)
  );

  cmp_serial #(.WIDTH(W), .SIGNED_EN(0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .a(a), .b(b), .is_signed(is_signed),
    .busy(busy_u), .done(done_u), .aeb(aeb_u), .agb(agb_u), .alb(alb_u)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Result {aeb,agb,alb} from plain arithmetic; latency from the highest differing bit.
  function automatic void ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                  output logic [2:0] r, output int n);
    int  p;
    logic gt;
    p = 0;
    for (int i = 0; i < W; i++) if (x[i] != y[i]) p = i;
    n  = W - p;
    gt = s ? ($signed(x) > $signed(y)) : (x > y);
    r  = (x == y) ? 3'b100 : (gt ? 3'b010 : 3'b001);
  endfunction

  always @(posedge clk) begin : model
    logic [2:0] r;
    int         n;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = 3'b000; m_left = 0; chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_res = m_pend;
        end
      end else if (start === 1'b1) begin
        ref_cmp(a, b, is_signed, r, n);
        m_pend = r; m_left = n; m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("cycle {busy,done,aeb,agb,alb}", {busy, done, aeb, agb, alb},
                      {m_busy, m_done, m_res});
  end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(negedge clk); a = x; b = y; is_signed = s; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [2:0] exp_res, input int exp_lat);
    int k;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) k = i;
    end
    check({name, " latency"}, k, exp_lat);
    check({name, " result"}, {aeb, agb, alb}, exp_res);
    check({name, " model"}, m_res, exp_res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int mode;
    int sh;
    logic [W-1:0] msk;
    rst = 1'b1; start = 1'b0; start_u = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {busy, done, aeb, agb, alb}, 5'b00000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle hold", {busy, done, aeb, agb, alb}, 5'b00000);

    launch(8'h80, 8'h7F, 1'b0); wait_done("unsigned early", 3'b010, 1);
    launch(8'h80, 8'h7F, 1'b1); wait_done("signed msb", 3'b001, 1);
    launch(8'hFF, 8'hFE, 1'b1); wait_done("signed lsb", 3'b010, 8);
    launch(8'h5A, 8'h5A, 1'b0); wait_done("equal", 3'b100, 8);
    launch(8'h12, 8'h13, 1'b0); wait_done("unsigned lsb", 3'b001, 8);

    // start held high through busy with new operands, then into the done cycle
    @(negedge clk); a = 8'h12; b = 8'h13; is_signed = 1'b0; start = 1'b1;
    @(negedge clk); a = 8'h00; b = 8'h00;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) k = i;
    end
    check("busy start latency", k, 8);
    check("busy start result", {aeb, agb, alb}, 3'b001);
    @(negedge clk); start = 1'b0;
    wait_done("back to back", 3'b100, 8);

    @(negedge clk); a = 8'h80; b = 8'h7F; is_signed = 1'b1; start_u = 1'b1;
    @(negedge clk); start_u = 1'b0;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (done_u === 1'b1) k = i;
    end
    check("unsigned build latency", k, 1);
    check("unsigned build result", {aeb_u, agb_u, alb_u}, 3'b010);

    launch(8'h01, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort outputs", {busy, done, aeb, agb, alb}, 5'b00000);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) k = 1;
    end
    check("abort no done", k, 0);
    launch(8'h03, 8'h05, 1'b0); wait_done("after abort", 3'b001, 6);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 2) == 0);
      is_signed = 1'($urandom_range(0, 1));
      a         = 8'($urandom);
      mode      = $urandom_range(0, 3);
      sh        = $urandom_range(0, W - 1);
      msk       = 8'((1 << sh) - 1) & 8'($urandom);
      if (mode == 0) b = 8'($urandom);
      else if (mode == 1) b = a;
      else b = a ^ (8'(1 << sh) | msk);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
